// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM sequencing PC/IR/regfile/ALU/memory,
// with memory-ready stall timeout, sticky fault code and retired-instruction count.
module mips_multicycle_ctrl #(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             branch,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic [3:0]       state,
  output logic [1:0]       fault,
  output logic [CNT_W-1:0] instr_count
);

  localparam int unsigned WAIT_W = 8;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_RTWB   = 4'd7,
    S_BEQEX  = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JEX    = 4'd11,
    S_HALT   = 4'd15
  } state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [1:0]         fault_q, fault_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // State, wait counter, fault and retire counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      fault_q <= FAULT_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, stall timeout, fault capture and retire counting
  always_comb begin
    logic stall;
    logic retire;
    state_d = state_q;
    wait_d  = wait_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    retire  = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
        else           stall   = 1'b1;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default: begin
            state_d = S_HALT;
            fault_d = FAULT_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (mem_ready) state_d = S_MEMWB;
        else           stall   = 1'b1;
      end
      S_MEMWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEMWR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else begin
          stall = 1'b1;
        end
      end
      S_RTEX:   state_d = S_RTWB;
      S_RTWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_BEQEX: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_JEX: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase

    // A not-ready cycle after MAX_WAIT counted stalls is a timeout
    if (stall) begin
      if (wait_q == WAIT_W'(MAX_WAIT)) begin
        state_d = S_HALT;
        fault_d = FAULT_TIMEOUT;
      end else begin
        wait_d = wait_q + WAIT_W'(1);
      end
    end

    // Counter starts fresh in whichever state comes next
    if (state_d != state_q) wait_d = '0;

    if (retire) cnt_d = cnt_q + CNT_W'(1);
  end

  // Moore control decode; request/write enables held low during reset
  always_comb begin
    pc_write   = 1'b0;
    branch     = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
      end
      S_RTEX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_RTWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BEQEX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        branch    = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JEX: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase

    if (reset) begin
      pc_write  = 1'b0;
      branch    = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign state       = state_q;
  assign fault       = fault_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-cycle expected-state plans built from
// instruction descriptions, checked against DUT state/controls/fault/count.
module tb_mips_multicycle_ctrl;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        pc_write, branch, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_src, fault;
  logic [3:0]  state;
  logic [31:0] instr_count;

  mips_multicycle_ctrl #(.MAX_WAIT(15), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .branch(branch), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_src(pc_src), .state(state), .fault(fault), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000, OP_LW = 6'b100011, OP_SW = 6'b101011;

  typedef struct packed {
    logic [3:0] st;
    logic       rdy;
    logic [5:0] op;
    logic       ret;
    logic [1:0] flt;
  } ent_t;

  ent_t        plan[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] cnt_m    = '0;

  logic [15:0] ctrl_w;
  logic [5:0]  en_w;
  assign ctrl_w = {pc_write, branch, i_or_d, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src};
  assign en_w   = {pc_write, branch, mem_read, mem_write, ir_write, reg_write};

  // Control word each state must present, written from the state table
  function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic rdy);
    logic pw, br, iod, mr, mw, irw, m2r, rd, rw, sa;
    logic [1:0] sb, op, ps;
    {pw, br, iod, mr, mw, irw, m2r, rd, rw, sa} = '0;
    sb = 2'b00; op = 2'b00; ps = 2'b00;
    case (st)
      4'd0:  begin mr = 1; sb = 2'b01; irw = rdy; pw = rdy; end
      4'd1:  sb = 2'b11;
      4'd2:  begin sa = 1; sb = 2'b10; end
      4'd3:  begin iod = 1; mr = 1; end
      4'd4:  begin m2r = 1; rw = 1; end
      4'd5:  begin iod = 1; mw = 1; end
      4'd6:  begin sa = 1; op = 2'b10; end
      4'd7:  begin rd = 1; rw = 1; end
      4'd8:  begin sa = 1; op = 2'b01; ps = 2'b01; br = 1; end
      4'd9:  begin sa = 1; sb = 2'b10; end
      4'd10: rw = 1;
      4'd11: begin ps = 2'b10; pw = 1; end
      default: ;
    endcase
    return {pw, br, iod, mr, mw, irw, m2r, rd, rw, sa, sb, op, ps};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] st, input logic rdy, input logic [5:0] op,
                     input logic ret, input logic [1:0] flt);
    ent_t e;
    e.st = st; e.rdy = rdy; e.op = op; e.ret = ret; e.flt = flt;
    plan.push_back(e);
  endtask

  // Expected cycle sequence of one instruction with given fetch/memory stalls
  task automatic instr(input logic [5:0] op, input int fw, input int mw);
    for (int i = 0; i < fw; i++) add(4'd0, 1'b0, op, 1'b0, 2'b00);
    add(4'd0, 1'b1, op, 1'b0, 2'b00);
    add(4'd1, 1'b1, op, 1'b0, 2'b00);
    case (op)
      OP_LW: begin
        add(4'd2, 1'b1, op, 1'b0, 2'b00);
        for (int i = 0; i < mw; i++) add(4'd3, 1'b0, op, 1'b0, 2'b00);
        add(4'd3, 1'b1, op, 1'b0, 2'b00);
        add(4'd4, 1'b1, op, 1'b1, 2'b00);
      end
      OP_SW: begin
        add(4'd2, 1'b1, op, 1'b0, 2'b00);
        for (int i = 0; i < mw; i++) add(4'd5, 1'b0, op, 1'b0, 2'b00);
        add(4'd5, 1'b1, op, 1'b1, 2'b00);
      end
      OP_R:    begin add(4'd6, 1'b1, op, 1'b0, 2'b00); add(4'd7, 1'b1, op, 1'b1, 2'b00); end
      OP_BEQ:  add(4'd8, 1'b1, op, 1'b1, 2'b00);
      OP_ADDI: begin add(4'd9, 1'b1, op, 1'b0, 2'b00); add(4'd10, 1'b1, op, 1'b1, 2'b00); end
      OP_J:    add(4'd11, 1'b1, op, 1'b1, 2'b00);
      default: ;
    endcase
  endtask

  task automatic halt_cycles(input int n, input logic [5:0] op, input logic [1:0] flt);
    for (int i = 0; i < n; i++) add(4'd15, 1'($urandom_range(0, 1)), op, 1'b0, flt);
  endtask

  // Drive and check every planned cycle; entered and left at a falling edge
  task automatic run_plan();
    ent_t e;
    while (plan.size() > 0) begin
      e = plan.pop_front();
      opcode = e.op; mem_ready = e.rdy;
      #1;
      chk("state", 32'(state), 32'(e.st));
      chk("ctrl", 32'(ctrl_w), 32'(exp_ctrl(e.st, e.rdy)));
      chk("fault", 32'(fault), 32'(e.flt));
      chk("instr_count", instr_count, cnt_m);
      if (e.ret) cnt_m = cnt_m + 32'd1;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_ready = 1'b1;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_en", 32'(en_w), 32'd0);
    @(negedge clk);
    chk("rst_hold_state", 32'(state), 32'd0);
    chk("rst_hold_fault", 32'(fault), 32'd0);
    chk("rst_hold_cnt", instr_count, 32'd0);
    reset = 1'b0; mem_ready = 1'b0;
    cnt_m = '0;
  endtask

  // Async reset in the middle of the cycle spent in exp_st
  task automatic async_mid(input logic [3:0] exp_st);
    mem_ready = 1'b0;
    #1;
    chk("pre_async_state", 32'(state), 32'(exp_st));
    #2 reset = 1'b1;
    #1;
    chk("async_state", 32'(state), 32'd0);
    chk("async_cnt", instr_count, 32'd0);
    chk("async_en", 32'(en_w), 32'd0);
    @(negedge clk);
    chk("async_hold_en", 32'(en_w), 32'd0);
    chk("async_hold_state", 32'(state), 32'd0);
    reset = 1'b0;
    cnt_m = '0;
  endtask

  initial begin
    reset = 1'b1; opcode = 6'd0; mem_ready = 1'b0;
    @(negedge clk);
    chk("init_state", 32'(state), 32'd0);
    chk("init_fault", 32'(fault), 32'd0);
    chk("init_cnt", instr_count, 32'd0);
    chk("init_en", 32'(en_w), 32'd0);
    reset = 1'b0;

    // addi, no waits: 0,1,9,10
    instr(OP_ADDI, 0, 0); run_plan();
    chk("addi_cnt_lit", instr_count, 32'd1);
    chk("addi_state_lit", 32'(state), 32'd0);

    // lw with 3 not-ready cycles in MEMRD
    instr(OP_LW, 0, 3); run_plan();
    chk("lw_cnt_lit", instr_count, 32'd2);

    // sw, beq, j back to back
    do_reset();
    instr(OP_SW, 0, 0); instr(OP_BEQ, 0, 0); instr(OP_J, 0, 0); run_plan();
    chk("swbeqj_cnt_lit", instr_count, 32'd3);

    // R-type with fetch stalls and sw with write stalls
    instr(OP_R, 2, 0); instr(OP_SW, 1, 4); run_plan();
    chk("rsw_cnt_lit", instr_count, 32'd5);

    // illegal opcode: HALT with fault 01, frozen for 20 cycles
    instr(6'b111111, 0, 0); halt_cycles(20, 6'b111111, 2'b01); run_plan();
    chk("illegal_fault_lit", 32'(fault), 32'd1);
    chk("illegal_state_lit", 32'(state), 32'd15);
    chk("illegal_cnt_lit", instr_count, 32'd5);
    do_reset();

    // fetch timeout: 16 not-ready cycles in FETCH
    for (int i = 0; i < 16; i++) add(4'd0, 1'b0, OP_ADDI, 1'b0, 2'b00);
    halt_cycles(3, OP_ADDI, 2'b10); run_plan();
    chk("fetch_to_fault_lit", 32'(fault), 32'd2);
    do_reset();

    // ready on the 16th fetch cycle wins
    instr(OP_ADDI, 15, 0); run_plan();
    chk("ready_wins_fault_lit", 32'(fault), 32'd0);
    chk("ready_wins_cnt_lit", instr_count, 32'd1);

    // MEMRD timeout
    add(4'd0, 1'b1, OP_LW, 1'b0, 2'b00); add(4'd1, 1'b1, OP_LW, 1'b0, 2'b00);
    add(4'd2, 1'b1, OP_LW, 1'b0, 2'b00);
    for (int i = 0; i < 16; i++) add(4'd3, 1'b0, OP_LW, 1'b0, 2'b00);
    halt_cycles(2, OP_LW, 2'b10); run_plan();
    chk("memrd_to_fault_lit", 32'(fault), 32'd2);
    do_reset();

    // async reset mid-RTEX
    instr(OP_ADDI, 0, 0);
    add(4'd0, 1'b1, OP_R, 1'b0, 2'b00); add(4'd1, 1'b1, OP_R, 1'b0, 2'b00);
    run_plan();
    async_mid(4'd6);

    // fetch resumes on first edge after release; then async reset mid-MEMRD wait
    instr(OP_J, 0, 0);
    add(4'd0, 1'b1, OP_LW, 1'b0, 2'b00); add(4'd1, 1'b1, OP_LW, 1'b0, 2'b00);
    add(4'd2, 1'b1, OP_LW, 1'b0, 2'b00);
    add(4'd3, 1'b0, OP_LW, 1'b0, 2'b00); add(4'd3, 1'b0, OP_LW, 1'b0, 2'b00);
    run_plan();
    async_mid(4'd3);

    instr(OP_BEQ, 0, 0); run_plan();
    chk("final_cnt_lit", instr_count, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore-style control FSM that sequences the shared multicycle MIPS datapath: PC, IR, register file, ALU and the unified byte-addressed memory.
- Each instruction takes 3–5 states; memory accesses stall on a ready handshake.
- Also counts retired instructions and latches a sticky fault on an illegal opcode or a memory timeout.
- Sits inside main, between the IR opcode field and the datapath enables.

Parameters:
- MAX_WAIT, 15, max cycles a memory state waits for mem_ready before a timeout fault (1..255).
- CNT_W, 32, width of instr_count.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- opcode  input  6  IR[31:26].
- mem_ready  input  1  memory access completes this cycle.
- pc_write  output  1  unconditional PC load.
- branch  output  1  PC load if ALU zero.
- i_or_d  output  1  memory address source: 0 = PC, 1 = ALUOut.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- ir_write  output  1  IR load.
- mem_to_reg  output  1  register write data: 1 = memory data register.
- reg_dst  output  1  destination: 1 = rd, 0 = rt.
- reg_write  output  1  register file write.
- alu_src_a  output  1  ALU A: 0 = PC, 1 = register A.
- alu_src_b  output  2  ALU B: 00 = reg B, 01 = 4, 10 = sign-extended immediate, 11 = immediate shifted left 2.
- alu_op  output  2  00 = add, 01 = sub, 10 = decode funct.
- pc_src  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  output  4  current state, for debug.
- fault  output  2  00 = none, 01 = illegal opcode, 10 = memory timeout.
- instr_count  output  CNT_W  retired instructions, wraps modulo 2^CNT_W.

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEX=6, RTWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11, HALT=15.
- Reset (async, any cycle, including mid-instruction or during a wait):
  - state=FETCH, fault=00, instr_count=0, wait counter=0.
  - While reset is high, every write/request output (pc_write, branch, mem_read, mem_write, ir_write, reg_write) is forced to 0.
- Outputs are decoded combinationally from state; any signal not listed for a state is 0.
  - FETCH: mem_read=1, alu_src_b=01, alu_op=00, pc_src=00. ir_write and pc_write = mem_ready. Stays in FETCH until mem_ready, then goes to DECODE.
  - DECODE: alu_src_b=11. Next state by opcode:
    - 100011 (lw) or 101011 (sw) -> MEMADR.
    - 000000 -> RTEX.
    - 000100 -> BEQEX.
    - 001000 -> ADDIEX.
    - 000010 -> JEX.
    - any other -> HALT with fault=01.
  - MEMADR: alu_src_a=1, alu_src_b=10. Next: lw -> MEMRD, sw -> MEMWR.
  - MEMRD: i_or_d=1, mem_read=1. Waits for mem_ready, then goes to MEMWB.
  - MEMWB: mem_to_reg=1, reg_write=1. Next: FETCH.
  - MEMWR: i_or_d=1, mem_write=1, held until mem_ready, then goes to FETCH.
  - RTEX: alu_src_a=1, alu_op=10. Next: RTWB.
  - RTWB: reg_dst=1, reg_write=1. Next: FETCH.
  - BEQEX: alu_src_a=1, alu_op=01, pc_src=01, branch=1. Next: FETCH.
  - ADDIEX: alu_src_a=1, alu_src_b=10. Next: ADDIWB.
  - ADDIWB: reg_write=1. Next: FETCH.
  - JEX: pc_src=10, pc_write=1. Next: FETCH.
  - HALT: all enables 0. Stays in HALT until reset; fault holds its value.
- Wait counter (FETCH, MEMRD, MEMWR):
  - Clears on entry to the state; increments each cycle mem_ready=0.
  - mem_ready=1 on the same cycle the count reaches MAX_WAIT counts as success (ready wins).
  - After MAX_WAIT not-ready cycles, the next not-ready cycle goes to HALT with fault=10.
- Latency with zero wait states: R-type, addi and lw-free paths take 4 cycles; lw takes 5; sw takes 4; beq and j take 3.
- instr_count increments by 1 on the last cycle of an instruction:
  - MEMWB, RTWB, ADDIWB, BEQEX, JEX.
  - MEMWR on the cycle mem_ready=1.
  - No increment for illegal opcodes or timeouts.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.

Test Plan:
- addi, opcode 001000 (instr 0x200A000A), mem_ready always 1 -> states 0,1,9,10,0. reg_write=1 only in state 10, with alu_src_b=10 in state 9. instr_count=1 after 4 cycles.
- lw, opcode 100011, mem_ready low for 3 cycles in MEMRD -> states 0,1,2,3,3,3,3,4,0. mem_read and i_or_d held 4 cycles in MEMRD. reg_write with mem_to_reg=1 in state 4. instr_count +1.
- sw then beq then j, back to back with zero wait -> mem_write pulses once in state 5. branch=1 with pc_src=01 in state 8. pc_write=1 with pc_src=10 in state 11. instr_count=3.
- Opcode 111111 -> DECODE goes to HALT (15) with fault=01. Outputs stay 0 and instr_count is frozen for 20 cycles; reset returns state to 0 and fault to 00.
- mem_ready held 0 in FETCH with MAX_WAIT=15 -> after 16 cycles in FETCH, state=15 and fault=10. A repeat with mem_ready=1 on the 16th cycle reaches DECODE and fault stays 00.
- reset asserted asynchronously mid-RTEX and mid-MEMRD wait -> state=0 and instr_count=0 immediately, with no clock edge needed. All enables read 0 while reset is high; normal fetch resumes on the first edge after release.
